// File: rtl/shl_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shl_arbiter_pkg
// Shared definitions for the shl_arbiter block: the sequencer state encoding
// and the default datapath width / requester count.
// -----------------------------------------------------------------------------
package shl_arbiter_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_NREQ      = 4;

endpackage : shl_arbiter_pkg

// File: rtl/shl_arbiter_shl.sv
// -----------------------------------------------------------------------------
// shl_arbiter_shl
// Shared SHL component: d = a << sh_amt, truncated to DATAWIDTH bits.
// Ports:
//   a      in  DATAWIDTH  operand
//   sh_amt in  DATAWIDTH  shift amount (values >= DATAWIDTH give 0)
//   d      out DATAWIDTH  shifted result
// -----------------------------------------------------------------------------
module shl_arbiter_shl
  import shl_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic [DATAWIDTH-1:0] d
);

  // Logical left shift; the shift operator zero-fills, so any amount of
  // DATAWIDTH or more flushes the result to 0 without a separate compare.
  always_comb begin
    d = a << sh_amt;
  end

endmodule : shl_arbiter_shl

// File: rtl/shl_arbiter.sv
// -----------------------------------------------------------------------------
// shl_arbiter
// Round-robin arbiter + sequencer sharing one SHL instance among NREQ
// requesters. One request is accepted at a time (IDLE), operands are latched
// and shifted (EXEC), and the registered result is presented to the granted
// requester until it acknowledges (RESP).
// Ports:
//   Clk         in   1               rising-edge clock
//   Rst         in   1               synchronous active-high reset
//   req_valid   in   NREQ            per-requester request valid
//   req_a       in   NREQ*DATAWIDTH  operand a, slice i for requester i
//   req_sh_amt  in   NREQ*DATAWIDTH  shift amount, slice i for requester i
//   req_ready   out  NREQ            one-hot accept strobe (IDLE only)
//   resp_valid  out  NREQ            one-hot result valid to granted requester
//   resp_d      out  DATAWIDTH       shared result bus
//   resp_ready  in   NREQ            per-requester result acknowledge
//   busy        out  1               state is not IDLE
//   grant_id    out  IDW             current / last granted requester
// -----------------------------------------------------------------------------
module shl_arbiter
  import shl_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int IDW       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_sh_amt,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           resp_valid,
  output logic [DATAWIDTH-1:0]      resp_d,
  input  logic [NREQ-1:0]           resp_ready,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_grant_id;
  logic [DATAWIDTH-1:0]  r_a;
  logic [DATAWIDTH-1:0]  r_sh;
  logic [DATAWIDTH-1:0]  r_resp_d;
  logic [NREQ-1:0]       r_resp_valid;

  logic                  w_found;
  logic [IDW-1:0]        w_winner;
  int                    w_idx;
  logic [NREQ-1:0]       w_req_ready;
  logic                  w_accept;
  logic                  w_resp_done;
  logic [DATAWIDTH-1:0]  w_shl_d;
  logic [IDW-1:0]        w_ptr_nxt;
  logic [NREQ-1:0]       w_grant_onehot;

  // Round-robin pick: first valid requester starting at r_rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx[IDW-1:0];
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Next-state, accept strobe and response-completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_resp_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_req_ready[w_winner] = 1'b1;
          w_accept              = 1'b1;
          w_state_nxt           = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted requester's acknowledge matters.
        if (resp_ready[r_grant_id]) begin
          w_resp_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Rotation pointer successor and one-hot of the granted requester.
  always_comb begin
    if (r_grant_id == IDW'(NREQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_grant_id + IDW'(1);
    end
    w_grant_onehot = NREQ'(1) << r_grant_id;
  end

  // Shared shifter, fed only from the captured operand registers.
  shl_arbiter_shl #(
    .DATAWIDTH (DATAWIDTH)
  ) u_shl (
    .a      (r_a),
    .sh_amt (r_sh),
    .d      (w_shl_d)
  );

  // State, operand capture, result and response-valid registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_a          <= '0;
      r_sh         <= '0;
      r_resp_d     <= '0;
      r_resp_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a        <= req_a[int'(w_winner)*DATAWIDTH +: DATAWIDTH];
            r_sh       <= req_sh_amt[int'(w_winner)*DATAWIDTH +: DATAWIDTH];
            r_grant_id <= w_winner;
          end else begin
            r_grant_id <= r_grant_id;
          end
        end
        ST_EXEC: begin
          r_resp_d     <= w_shl_d;
          r_resp_valid <= w_grant_onehot;
        end
        ST_RESP: begin
          // Pointer moves on completion only, never on grant.
          if (w_resp_done) begin
            r_rr_ptr     <= w_ptr_nxt;
            r_resp_valid <= '0;
          end else begin
            r_resp_valid <= r_resp_valid;
          end
        end
        default: begin
          r_resp_valid <= '0;
        end
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_d     = r_resp_d;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_grant_id;

endmodule : shl_arbiter
